reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Out-of-order issue buffer for integer, branch and jump instructions. Sits between the dispatcher and the ALU.
- Holds dispatched instructions until both source operands are valid. Snoops the ALU and LSB result broadcasts to capture pending operands.
- Issues at most one ready instruction per cycle to the ALU through the `rs_to_alu_*` interface.

Parameters:
- RS_SIZE, 16, number of entries (power of two)
- RS_IDX_W, 4, log2(RS_SIZE)
- ROB_TAG_W, 5, width of wrapped ROB position (`ROB_WRAP_POS_TYPE`)
- OPENUM_W, 6, width of `OPENUM_TYPE`

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- rdy  in  1  global ready; state holds when 0
- clr  in  1  synchronous flush (mispredict)
- dsp_to_rs_enable  in  1  dispatch valid
- dsp_to_rs_openum  in  OPENUM_W  operation
- dsp_to_rs_rob_pos  in  ROB_TAG_W  destination ROB tag
- dsp_to_rs_rs1_ready  in  1  rs1 value valid
- dsp_to_rs_rs1_val  in  32  rs1 value
- dsp_to_rs_rs1_tag  in  ROB_TAG_W  producer tag when not ready
- dsp_to_rs_rs2_ready, dsp_to_rs_rs2_val, dsp_to_rs_rs2_tag  in  1/32/ROB_TAG_W  same for rs2
- dsp_to_rs_imm  in  32  immediate
- dsp_to_rs_pc  in  32  instruction PC
- rs_full  out  1  no free entry (combinational from valid bits)
- alu_bc_enable, alu_bc_rob_pos, alu_bc_val  in  1/ROB_TAG_W/32  ALU broadcast
- lsb_bc_enable, lsb_bc_rob_pos, lsb_bc_val  in  1/ROB_TAG_W/32  LSB broadcast
- rs_to_alu_enable  out  1  issue valid (registered)
- rs_to_alu_openum, rs_to_alu_rob_pos, rs_to_alu_rs1_val, rs_to_alu_rs2_val, rs_to_alu_imm, rs_to_alu_pc  out  registered issue payload

Behaviour:
- Reset: when rst=0, immediately clear all valid bits. All `rs_to_alu_*` outputs go to 0; `rs_full`=0.
- clr=1 at a clock edge (rst=1): invalidate all entries, drive `rs_to_alu_enable`<=0, and ignore any dispatch in that cycle. clr has priority over rdy.
- rdy=0: no state change, outputs hold.
- Entry state:
  - valid, openum, rob_pos, imm, pc
  - per-operand: rdy bit, val, tag
- Dispatch (enable=1, not full):
  - Write to the lowest-index free entry.
  - Operand bypass: if an operand is not ready and its tag equals an enabled ALU or LSB broadcast tag in the same cycle, store it ready with the broadcast value.
  - Dispatch while `rs_full`=1 is a protocol violation. The request is dropped and the bench asserts on it.
- Wakeup: each edge, every valid entry with a pending operand whose tag matches an enabled broadcast sets that operand's rdy bit and captures the value. If both broadcasts match, the ALU broadcast wins (cannot occur legally).
- Select and issue:
  - An entry is ready when valid and both rdy bits are registered 1. Wakeup is visible for selection one cycle later; there is no same-edge wake-and-issue.
  - At each edge, choose the lowest-index ready entry. Load its payload into the `rs_to_alu_*` registers, set enable=1, and clear the entry's valid bit.
  - If no entry is ready: enable<=0 and payload registers hold their old values.
- Latency: dispatch at edge N with both operands ready -> `rs_to_alu_enable`=1 after edge N+1 -> ALU broadcast after edge N+2.
- Simultaneous dispatch and issue: a slot freed by issue at edge N is reusable by dispatch from edge N+1. A newly written entry is never issued at its own write edge.
- `rs_full` = all valid bits set. It is evaluated from registered state, so full deasserts the cycle after an issue.
- Operand values are stored unmodified, 32 bits. No arithmetic is performed in this block.

Decomposition:
- `definition.v` (shared):
  - `OPENUM_*` codes, `OPENUM_TYPE`, `DATA_TYPE`, `ADDR_TYPE`, `ROB_WRAP_POS_TYPE`
  - new `RS_SIZE` and `RS_ID_TYPE`
  - `TRUE`/`FALSE`
- One sub-module, `rs_priority_enc`: an RS_SIZE-input lowest-index priority encoder with a found flag. It is instantiated twice, once for free-slot search and once for ready-slot search.

Test Plan:
- Reset/flush:
  - After rst release: `rs_to_alu_enable`=0 and `rs_full`=0.
  - Dispatch 3 entries, assert clr for one edge -> no issue for the next 4 cycles, and `rs_full` stays 0.
- Ready dispatch: ADDI, rs1 ready val=5, imm=7, rob_pos=3 at edge N -> after N+1: enable=1, openum=ADDI, rs1_val=5, imm=7, rob_pos=3. After N+2: enable=0.
- Wakeup: ADD with rs1 pending tag=9, rs2 ready=2. At the next edge `alu_bc_enable`=1, rob_pos=9, val=40 -> issue one cycle later with rs1_val=40, rs2_val=2. No issue before that.
- Dispatch bypass: dispatch BEQ with rs2 tag=4 in the same cycle as `lsb_bc` tag=4, val=0x100 -> issued next edge with rs2_val=0x100.
- Full/priority:
  - Fill 16 entries, all with pending tag=1 -> `rs_full`=1.
  - Broadcast tag=1 -> entries issue one per cycle, index 0 first, over 16 consecutive cycles.
  - `rs_full`=0 after the first issue.
- rdy stall: hold rdy=0 for 3 cycles while a ready entry exists -> outputs and entries frozen. Issue occurs on the first edge with rdy=1.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared types, opcodes and sizing for the integer/branch reservation station.
// Entry layout is one packed struct so select and dispatch move whole records.
package reservation_station_pkg;

    localparam int RS_SIZE   = 16;
    localparam int RS_IDX_W  = 4;
    localparam int ROB_TAG_W = 5;
    localparam int OPENUM_W  = 6;

    typedef logic [OPENUM_W-1:0]  openum_t;
    typedef logic [31:0]          data_t;
    typedef logic [31:0]          addr_t;
    typedef logic [ROB_TAG_W-1:0] rob_pos_t;
    typedef logic [RS_IDX_W-1:0]  rs_id_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam openum_t OPENUM_NOP  = 6'd0;
    localparam openum_t OPENUM_ADD  = 6'd1;
    localparam openum_t OPENUM_SUB  = 6'd2;
    localparam openum_t OPENUM_ADDI = 6'd3;
    localparam openum_t OPENUM_BEQ  = 6'd4;
    localparam openum_t OPENUM_BNE  = 6'd5;
    localparam openum_t OPENUM_JAL  = 6'd6;
    localparam openum_t OPENUM_JALR = 6'd7;

    typedef struct packed {
        openum_t  openum;
        rob_pos_t rob_pos;
        logic     rs1_rdy;
        data_t    rs1_val;
        rob_pos_t rs1_tag;
        logic     rs2_rdy;
        data_t    rs2_val;
        rob_pos_t rs2_tag;
        data_t    imm;
        addr_t    pc;
    } rs_entry_t;

    function automatic logic bc_hit(input logic en, input rob_pos_t bc_tag, input rob_pos_t tag);
        return en && (bc_tag == tag);
    endfunction

endpackage

// File: rtl/rs_priority_enc.sv
// Lowest-index priority encoder with a found flag; used for free-slot and
// ready-slot search.
module rs_priority_enc
    import reservation_station_pkg::*;
#(
    parameter int N     = RS_SIZE,
    parameter int IDX_W = RS_IDX_W
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan downward so the last assignment is the lowest set index.
    always_comb begin
        idx   = '0;
        found = FALSE;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = TRUE;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Out-of-order issue buffer: holds dispatched ALU ops until both operands are
// captured (directly, by dispatch bypass or by broadcast wakeup), issues one per cycle.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  logic     clr,
    input  logic     dsp_to_rs_enable,
    input  openum_t  dsp_to_rs_openum,
    input  rob_pos_t dsp_to_rs_rob_pos,
    input  logic     dsp_to_rs_rs1_ready,
    input  data_t    dsp_to_rs_rs1_val,
    input  rob_pos_t dsp_to_rs_rs1_tag,
    input  logic     dsp_to_rs_rs2_ready,
    input  data_t    dsp_to_rs_rs2_val,
    input  rob_pos_t dsp_to_rs_rs2_tag,
    input  data_t    dsp_to_rs_imm,
    input  addr_t    dsp_to_rs_pc,
    output logic     rs_full,
    input  logic     alu_bc_enable,
    input  rob_pos_t alu_bc_rob_pos,
    input  data_t    alu_bc_val,
    input  logic     lsb_bc_enable,
    input  rob_pos_t lsb_bc_rob_pos,
    input  data_t    lsb_bc_val,
    output logic     rs_to_alu_enable,
    output openum_t  rs_to_alu_openum,
    output rob_pos_t rs_to_alu_rob_pos,
    output data_t    rs_to_alu_rs1_val,
    output data_t    rs_to_alu_rs2_val,
    output data_t    rs_to_alu_imm,
    output addr_t    rs_to_alu_pc
);

    rs_entry_t          entries [RS_SIZE];
    logic [RS_SIZE-1:0] valid;
    logic [RS_SIZE-1:0] ready_vec;
    rs_id_t             free_idx;
    rs_id_t             sel_idx;
    logic               free_found;
    logic               sel_found;
    logic               do_dispatch;
    rs_entry_t          new_entry;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = valid[i] & entries[i].rs1_rdy & entries[i].rs2_rdy;
        end
    end

    assign rs_full     = &valid;
    assign do_dispatch = dsp_to_rs_enable && free_found;

    rs_priority_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_enc (
        .req   (~valid),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_priority_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_sel_enc (
        .req   (ready_vec),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // Dispatch bypass: capture a result broadcast in the same cycle as the write.
    always_comb begin
        new_entry         = '0;
        new_entry.openum  = dsp_to_rs_openum;
        new_entry.rob_pos = dsp_to_rs_rob_pos;
        new_entry.imm     = dsp_to_rs_imm;
        new_entry.pc      = dsp_to_rs_pc;
        new_entry.rs1_tag = dsp_to_rs_rs1_tag;
        new_entry.rs2_tag = dsp_to_rs_rs2_tag;
        new_entry.rs1_rdy = dsp_to_rs_rs1_ready;
        new_entry.rs1_val = dsp_to_rs_rs1_val;
        new_entry.rs2_rdy = dsp_to_rs_rs2_ready;
        new_entry.rs2_val = dsp_to_rs_rs2_val;
        if (!dsp_to_rs_rs1_ready) begin
            if (bc_hit(alu_bc_enable, alu_bc_rob_pos, dsp_to_rs_rs1_tag)) begin
                new_entry.rs1_rdy = TRUE;
                new_entry.rs1_val = alu_bc_val;
            end else if (bc_hit(lsb_bc_enable, lsb_bc_rob_pos, dsp_to_rs_rs1_tag)) begin
                new_entry.rs1_rdy = TRUE;
                new_entry.rs1_val = lsb_bc_val;
            end
        end
        if (!dsp_to_rs_rs2_ready) begin
            if (bc_hit(alu_bc_enable, alu_bc_rob_pos, dsp_to_rs_rs2_tag)) begin
                new_entry.rs2_rdy = TRUE;
                new_entry.rs2_val = alu_bc_val;
            end else if (bc_hit(lsb_bc_enable, lsb_bc_rob_pos, dsp_to_rs_rs2_tag)) begin
                new_entry.rs2_rdy = TRUE;
                new_entry.rs2_val = lsb_bc_val;
            end
        end
    end

    // Control and issue registers: valid bits and the ALU-facing payload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid             <= '0;
            rs_to_alu_enable  <= FALSE;
            rs_to_alu_openum  <= '0;
            rs_to_alu_rob_pos <= '0;
            rs_to_alu_rs1_val <= '0;
            rs_to_alu_rs2_val <= '0;
            rs_to_alu_imm     <= '0;
            rs_to_alu_pc      <= '0;
        end else if (clr) begin
            valid            <= '0;
            rs_to_alu_enable <= FALSE;
        end else if (rdy) begin
            rs_to_alu_enable <= sel_found;
            if (sel_found) begin
                valid[sel_idx]    <= FALSE;
                rs_to_alu_openum  <= entries[sel_idx].openum;
                rs_to_alu_rob_pos <= entries[sel_idx].rob_pos;
                rs_to_alu_rs1_val <= entries[sel_idx].rs1_val;
                rs_to_alu_rs2_val <= entries[sel_idx].rs2_val;
                rs_to_alu_imm     <= entries[sel_idx].imm;
                rs_to_alu_pc      <= entries[sel_idx].pc;
            end
            if (do_dispatch) begin
                valid[free_idx] <= TRUE;
            end
        end
    end

    // Entry payload: wakeup of pending operands, then the dispatch write into a free slot.
    always_ff @(posedge clk) begin
        if (rdy && !clr) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (valid[i] && !entries[i].rs1_rdy) begin
                    if (bc_hit(alu_bc_enable, alu_bc_rob_pos, entries[i].rs1_tag)) begin
                        entries[i].rs1_rdy <= TRUE;
                        entries[i].rs1_val <= alu_bc_val;
                    end else if (bc_hit(lsb_bc_enable, lsb_bc_rob_pos, entries[i].rs1_tag)) begin
                        entries[i].rs1_rdy <= TRUE;
                        entries[i].rs1_val <= lsb_bc_val;
                    end
                end
                if (valid[i] && !entries[i].rs2_rdy) begin
                    if (bc_hit(alu_bc_enable, alu_bc_rob_pos, entries[i].rs2_tag)) begin
                        entries[i].rs2_rdy <= TRUE;
                        entries[i].rs2_val <= alu_bc_val;
                    end else if (bc_hit(lsb_bc_enable, lsb_bc_rob_pos, entries[i].rs2_tag)) begin
                        entries[i].rs2_rdy <= TRUE;
                        entries[i].rs2_val <= lsb_bc_val;
                    end
                end
            end
            if (do_dispatch) begin
                entries[free_idx] <= new_entry;
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: table of single-op dispatch vectors
// plus hand-written reset/flush, wakeup, full/priority and stall sequences.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic     clk = 1'b0;
    logic     rst, rdy, clr;
    logic     dsp_to_rs_enable;
    openum_t  dsp_to_rs_openum;
    rob_pos_t dsp_to_rs_rob_pos;
    logic     dsp_to_rs_rs1_ready;
    data_t    dsp_to_rs_rs1_val;
    rob_pos_t dsp_to_rs_rs1_tag;
    logic     dsp_to_rs_rs2_ready;
    data_t    dsp_to_rs_rs2_val;
    rob_pos_t dsp_to_rs_rs2_tag;
    data_t    dsp_to_rs_imm;
    addr_t    dsp_to_rs_pc;
    logic     rs_full;
    logic     alu_bc_enable;
    rob_pos_t alu_bc_rob_pos;
    data_t    alu_bc_val;
    logic     lsb_bc_enable;
    rob_pos_t lsb_bc_rob_pos;
    data_t    lsb_bc_val;
    logic     rs_to_alu_enable;
    openum_t  rs_to_alu_openum;
    rob_pos_t rs_to_alu_rob_pos;
    data_t    rs_to_alu_rs1_val;
    data_t    rs_to_alu_rs2_val;
    data_t    rs_to_alu_imm;
    addr_t    rs_to_alu_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reservation_station dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .clr                 (clr),
        .dsp_to_rs_enable    (dsp_to_rs_enable),
        .dsp_to_rs_openum    (dsp_to_rs_openum),
        .dsp_to_rs_rob_pos   (dsp_to_rs_rob_pos),
        .dsp_to_rs_rs1_ready (dsp_to_rs_rs1_ready),
        .dsp_to_rs_rs1_val   (dsp_to_rs_rs1_val),
        .dsp_to_rs_rs1_tag   (dsp_to_rs_rs1_tag),
        .dsp_to_rs_rs2_ready (dsp_to_rs_rs2_ready),
        .dsp_to_rs_rs2_val   (dsp_to_rs_rs2_val),
        .dsp_to_rs_rs2_tag   (dsp_to_rs_rs2_tag),
        .dsp_to_rs_imm       (dsp_to_rs_imm),
        .dsp_to_rs_pc        (dsp_to_rs_pc),
        .rs_full             (rs_full),
        .alu_bc_enable       (alu_bc_enable),
        .alu_bc_rob_pos      (alu_bc_rob_pos),
        .alu_bc_val          (alu_bc_val),
        .lsb_bc_enable       (lsb_bc_enable),
        .lsb_bc_rob_pos      (lsb_bc_rob_pos),
        .lsb_bc_val          (lsb_bc_val),
        .rs_to_alu_enable    (rs_to_alu_enable),
        .rs_to_alu_openum    (rs_to_alu_openum),
        .rs_to_alu_rob_pos   (rs_to_alu_rob_pos),
        .rs_to_alu_rs1_val   (rs_to_alu_rs1_val),
        .rs_to_alu_rs2_val   (rs_to_alu_rs2_val),
        .rs_to_alu_imm       (rs_to_alu_imm),
        .rs_to_alu_pc        (rs_to_alu_pc)
    );

    typedef struct {
        openum_t  op;
        rob_pos_t rob;
        logic     r1_rdy;
        data_t    r1_val;
        rob_pos_t r1_tag;
        logic     r2_rdy;
        data_t    r2_val;
        rob_pos_t r2_tag;
        data_t    imm;
        addr_t    pc;
        logic     abc_en;
        rob_pos_t abc_tag;
        data_t    abc_val;
        logic     lbc_en;
        rob_pos_t lbc_tag;
        data_t    lbc_val;
        data_t    exp_r1;
        data_t    exp_r2;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input openum_t op, input rob_pos_t rob,
                            input logic r1r, input data_t r1v, input rob_pos_t r1t,
                            input logic r2r, input data_t r2v, input rob_pos_t r2t,
                            input data_t imm, input addr_t pc);
        dsp_to_rs_enable    = 1'b1;
        dsp_to_rs_openum    = op;
        dsp_to_rs_rob_pos   = rob;
        dsp_to_rs_rs1_ready = r1r;
        dsp_to_rs_rs1_val   = r1v;
        dsp_to_rs_rs1_tag   = r1t;
        dsp_to_rs_rs2_ready = r2r;
        dsp_to_rs_rs2_val   = r2v;
        dsp_to_rs_rs2_tag   = r2t;
        dsp_to_rs_imm       = imm;
        dsp_to_rs_pc        = pc;
    endtask

    // Dispatching into a full station is a protocol violation by the bench itself.
    always @(negedge clk) begin
        if (rst && dsp_to_rs_enable && rs_full) begin
            checks++;
            errors++;
            $display("FAIL dispatch_while_full: enable=1 with rs_full=1");
        end
    end

    initial begin
        vecs[0] = '{OPENUM_ADDI, 5'd3,  1'b1, 32'd5,        5'd0, 1'b1, 32'd0,        5'd0,
                    32'd7,        32'h1000, 1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 32'd0,
                    32'd5,        32'd0};
        vecs[1] = '{OPENUM_ADD,  5'd10, 1'b1, 32'h12345678, 5'd0, 1'b1, 32'hFFFFFFFF, 5'd0,
                    32'd0,        32'h1004, 1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 32'd0,
                    32'h12345678, 32'hFFFFFFFF};
        vecs[2] = '{OPENUM_BEQ,  5'd11, 1'b1, 32'h11,       5'd0, 1'b0, 32'd0,        5'd4,
                    32'h10,       32'h80,   1'b0, 5'd0,  32'd0,        1'b1, 5'd4, 32'h100,
                    32'h11,       32'h100};
        vecs[3] = '{OPENUM_SUB,  5'd31, 1'b0, 32'd0,        5'd7, 1'b1, 32'd3,        5'd0,
                    32'd0,        32'h2000, 1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0, 32'd0,
                    32'hDEADBEEF, 32'd3};
        vecs[4] = '{OPENUM_JALR, 5'd0,  1'b0, 32'd0,        5'd6, 1'b0, 32'd0,        5'd8,
                    32'hFFFFFFFC, 32'h2004, 1'b1, 5'd6,  32'h40,       1'b1, 5'd8, 32'h80,
                    32'h40,       32'h80};
        vecs[5] = '{OPENUM_ADD,  5'd5,  1'b1, 32'd9,        5'd12, 1'b1, 32'd1,       5'd0,
                    32'd0,        32'h2008, 1'b1, 5'd12, 32'h77,       1'b0, 5'd0, 32'd0,
                    32'd9,        32'd1};

        rst = 1'b1; rdy = 1'b1; clr = 1'b0;
        dsp_to_rs_enable = 1'b0; dsp_to_rs_openum = '0; dsp_to_rs_rob_pos = '0;
        dsp_to_rs_rs1_ready = 1'b0; dsp_to_rs_rs1_val = '0; dsp_to_rs_rs1_tag = '0;
        dsp_to_rs_rs2_ready = 1'b0; dsp_to_rs_rs2_val = '0; dsp_to_rs_rs2_tag = '0;
        dsp_to_rs_imm = '0; dsp_to_rs_pc = '0;
        alu_bc_enable = 1'b0; alu_bc_rob_pos = '0; alu_bc_val = '0;
        lsb_bc_enable = 1'b0; lsb_bc_rob_pos = '0; lsb_bc_val = '0;

        #2 rst = 1'b0;
        #1;
        check("reset_enable", 32'(rs_to_alu_enable), 32'd0);
        check("reset_full", 32'(rs_full), 32'd0);
        check("reset_rs1_val", rs_to_alu_rs1_val, 32'd0);
        check("reset_pc", rs_to_alu_pc, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("post_reset_enable", 32'(rs_to_alu_enable), 32'd0);
        check("post_reset_full", 32'(rs_full), 32'd0);

        for (int v = 0; v < 6; v++) begin
            dispatch(vecs[v].op, vecs[v].rob, vecs[v].r1_rdy, vecs[v].r1_val, vecs[v].r1_tag,
                     vecs[v].r2_rdy, vecs[v].r2_val, vecs[v].r2_tag, vecs[v].imm, vecs[v].pc);
            alu_bc_enable = vecs[v].abc_en; alu_bc_rob_pos = vecs[v].abc_tag; alu_bc_val = vecs[v].abc_val;
            lsb_bc_enable = vecs[v].lbc_en; lsb_bc_rob_pos = vecs[v].lbc_tag; lsb_bc_val = vecs[v].lbc_val;
            tick();
            dsp_to_rs_enable = 1'b0; alu_bc_enable = 1'b0; lsb_bc_enable = 1'b0;
            check($sformatf("vec%0d_no_issue_at_write", v), 32'(rs_to_alu_enable), 32'd0);
            tick();
            check($sformatf("vec%0d_enable", v), 32'(rs_to_alu_enable), 32'd1);
            check($sformatf("vec%0d_openum", v), 32'(rs_to_alu_openum), 32'(vecs[v].op));
            check($sformatf("vec%0d_rob_pos", v), 32'(rs_to_alu_rob_pos), 32'(vecs[v].rob));
            check($sformatf("vec%0d_rs1_val", v), rs_to_alu_rs1_val, vecs[v].exp_r1);
            check($sformatf("vec%0d_rs2_val", v), rs_to_alu_rs2_val, vecs[v].exp_r2);
            check($sformatf("vec%0d_imm", v), rs_to_alu_imm, vecs[v].imm);
            check($sformatf("vec%0d_pc", v), rs_to_alu_pc, vecs[v].pc);
            tick();
            check($sformatf("vec%0d_enable_drop", v), 32'(rs_to_alu_enable), 32'd0);
        end

        // Flush: three pending entries plus a ready dispatch coincident with clr.
        for (int i = 0; i < 3; i++) begin
            dispatch(OPENUM_ADD, rob_pos_t'(i), 1'b0, 32'd0, 5'd20, 1'b1, 32'd1, 5'd0, 32'd0, 32'h3000);
            tick();
        end
        dispatch(OPENUM_ADDI, 5'd9, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0, 32'd1, 32'h3010);
        clr = 1'b1;
        tick();
        clr = 1'b0; dsp_to_rs_enable = 1'b0;
        alu_bc_enable = 1'b1; alu_bc_rob_pos = 5'd20; alu_bc_val = 32'h99;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("clr_no_issue_%0d", i), 32'(rs_to_alu_enable), 32'd0);
            check($sformatf("clr_full_%0d", i), 32'(rs_full), 32'd0);
        end
        alu_bc_enable = 1'b0;

        // Wakeup through the ALU broadcast; selection sees it one edge later.
        dispatch(OPENUM_ADD, 5'd12, 1'b0, 32'd0, 5'd9, 1'b1, 32'd2, 5'd0, 32'd0, 32'h4000);
        tick();
        dsp_to_rs_enable = 1'b0;
        alu_bc_enable = 1'b1; alu_bc_rob_pos = 5'd9; alu_bc_val = 32'd40;
        tick();
        alu_bc_enable = 1'b0;
        check("wake_no_issue_same_edge", 32'(rs_to_alu_enable), 32'd0);
        tick();
        check("wake_enable", 32'(rs_to_alu_enable), 32'd1);
        check("wake_rob_pos", 32'(rs_to_alu_rob_pos), 32'd12);
        check("wake_rs1_val", rs_to_alu_rs1_val, 32'd40);
        check("wake_rs2_val", rs_to_alu_rs2_val, 32'd2);
        tick();
        check("wake_enable_drop", 32'(rs_to_alu_enable), 32'd0);

        // Fill all entries waiting on tag 1, then release them together.
        for (int i = 0; i < RS_SIZE; i++) begin
            dispatch(OPENUM_ADD, rob_pos_t'(i), 1'b0, 32'd0, 5'd1, 1'b1, 32'(i), 5'd0, 32'd0, 32'h5000);
            tick();
            if (i == RS_SIZE - 2) check("fill_not_full_yet", 32'(rs_full), 32'd0);
        end
        dsp_to_rs_enable = 1'b0;
        check("fill_full", 32'(rs_full), 32'd1);
        check("fill_no_issue", 32'(rs_to_alu_enable), 32'd0);
        alu_bc_enable = 1'b1; alu_bc_rob_pos = 5'd1; alu_bc_val = 32'h55;
        tick();
        alu_bc_enable = 1'b0;
        check("fill_wake_no_issue", 32'(rs_to_alu_enable), 32'd0);
        for (int i = 0; i < RS_SIZE; i++) begin
            tick();
            check($sformatf("drain%0d_enable", i), 32'(rs_to_alu_enable), 32'd1);
            check($sformatf("drain%0d_rob_pos", i), 32'(rs_to_alu_rob_pos), 32'(i));
            check($sformatf("drain%0d_rs2_val", i), rs_to_alu_rs2_val, 32'(i));
            if (i == 0) begin
                check("drain0_rs1_val", rs_to_alu_rs1_val, 32'h55);
                check("drain0_full_clear", 32'(rs_full), 32'd0);
            end
        end
        tick();
        check("drain_done_enable", 32'(rs_to_alu_enable), 32'd0);
        check("drain_done_full", 32'(rs_full), 32'd0);

        // rdy stall: outputs and queued entry frozen, issue on first rdy=1 edge.
        dispatch(OPENUM_ADDI, 5'd21, 1'b1, 32'd100, 5'd0, 1'b1, 32'd0, 5'd0, 32'd1, 32'h6000);
        tick();
        dispatch(OPENUM_ADDI, 5'd22, 1'b1, 32'd200, 5'd0, 1'b1, 32'd0, 5'd0, 32'd2, 32'h6004);
        tick();
        dsp_to_rs_enable = 1'b0;
        check("stall_pre_enable", 32'(rs_to_alu_enable), 32'd1);
        check("stall_pre_rob_pos", 32'(rs_to_alu_rob_pos), 32'd21);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d_enable", i), 32'(rs_to_alu_enable), 32'd1);
            check($sformatf("stall%0d_rob_pos", i), 32'(rs_to_alu_rob_pos), 32'd21);
            check($sformatf("stall%0d_rs1_val", i), rs_to_alu_rs1_val, 32'd100);
        end
        rdy = 1'b1;
        tick();
        check("stall_release_enable", 32'(rs_to_alu_enable), 32'd1);
        check("stall_release_rob_pos", 32'(rs_to_alu_rob_pos), 32'd22);
        check("stall_release_rs1_val", rs_to_alu_rs1_val, 32'd200);
        tick();
        check("stall_done_enable", 32'(rs_to_alu_enable), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
